prga_decrypt: RTL and testbench
===============================

PRGA_DECRYPT -- requirements
Module: prga_decrypt

Interface
REQ-001 Parameter MSG_LEN, default 32, meaning number of ciphertext bytes processed (1..256).
REQ-002 Parameter CHECK_EN, default 1, meaning plaintext character check enabled.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 In_Start  input  1  level; begins decryption when sampled high in IDLE (driven by shuffler Init_Finish).
REQ-006 Finish_ack  input  1  releases DONE back to IDLE.
REQ-007 s_addr  output  8  S-RAM address.
REQ-008 s_data  output  8  S-RAM write data.
REQ-009 s_wren  output  1  S-RAM write enable.
REQ-010 s_q  input  8  S-RAM read data.
REQ-011 rom_addr  output  $clog2(MSG_LEN)  ciphertext ROM address.
REQ-012 rom_q  input  8  ciphertext ROM read data.
REQ-013 out_addr  output  $clog2(MSG_LEN)  plaintext RAM address.
REQ-014 out_data  output  8  plaintext byte.
REQ-015 out_wren  output  1  plaintext RAM write enable, one cycle per byte.
REQ-016 Decrypt_Finish  output  1  high only in DONE.
REQ-017 Key_Invalid  output  1  high in DONE when a byte failed the character check; held until leaving DONE.

Function
REQ-018 Memory timing: s_q/rom_q valid at the second rising edge after the address register updates; every read uses SEND, WAIT, CAPTURE states.
REQ-019 States, one cycle each unless stated: IDLE, INC_I, SEND_SI, WAIT_SI, CAP_SI, SEND_SJ, WAIT_SJ, CAP_SJ, WR_SI, WR_SJ, SEND_F, WAIT_F, CAP_F, NEXT_K, DONE.
REQ-020 IDLE: i=0, j=0, k=0; In_Start high -> INC_I; otherwise stay.
REQ-021 INC_I: i <= i+1 (mod 256).
REQ-022 CAP_SI: si <= s_q; j <= j+s_q (mod 256).
REQ-023 CAP_SJ: sj <= s_q.
REQ-024 WR_SI: s_addr=i, s_data=sj, s_wren=1; WR_SJ: s_addr=j, s_data=si, s_wren=1; s_wren=0 in all other states.
REQ-025 SEND_F: s_addr <= si+sj (mod 256), rom_addr <= k concurrently; one WAIT_F serves both reads.
REQ-026 CAP_F: out_addr=k, out_data=s_q XOR rom_q, out_wren=1 for exactly this cycle.
REQ-027 Check (CHECK_EN=1): byte valid iff 0x61..0x7A or 0x20; invalid byte is still written, invalid flag set, next state DONE.
REQ-028 NEXT_K: k==MSG_LEN-1 -> DONE; else k <= k+1, -> INC_I.
REQ-029 DONE: Finish_ack high -> IDLE (flags cleared); else stay; In_Start ignored.
REQ-030 Per-byte latency fixed at 13 cycles; valid full message completes in 1+13*MSG_LEN cycles from In_Start sample.
REQ-031 i==j: both writes performed; resulting S unchanged.
REQ-032 Illegal state encoding -> IDLE next cycle.

Reset
REQ-033 rst high: state=IDLE; i, j, k, si, sj=0; s_addr, s_data, rom_addr, out_addr, out_data=0; s_wren, out_wren, Decrypt_Finish, Key_Invalid=0.
REQ-034 rst mid-operation aborts at next edge; no further writes to S-RAM or plaintext RAM.

Structure
REQ-035 State enum, valid-character bounds (0x20, 0x61, 0x7A) and default MSG_LEN live in shared package rc4_pkg, also used by the shuffler-side control.
REQ-036 Single module; no sub-module required; wren/finish outputs decoded from state bits.

Verification
REQ-037 S identity (S[x]=x), ROM[0]=0x63, MSG_LEN=1 -> out_addr 0, out_data 0x61, Key_Invalid=0, Decrypt_Finish at cycle 14.
REQ-038 Identity S, ROM[0]=0x02 -> out_data 0x00 written once, Key_Invalid=1, DONE without processing byte 1.
REQ-039 Known RC4 key 0x000249 S-array preloaded, 32-byte ciphertext -> 32 plaintext bytes match golden model, exactly 32 out_wren pulses, j wrap past 255 exercised.
REQ-040 Assert rst during WR_SI of byte 5 -> all outputs zero next cycle, no further s_wren/out_wren until new In_Start.
REQ-041 DONE with Finish_ack low 20 cycles, In_Start high -> stays DONE; Finish_ack pulse -> IDLE, Decrypt_Finish and Key_Invalid low.

Source files
------------

// File: rtl/rc4_pkg.sv
// rc4_pkg -- shared RC4 definitions for the shuffler and PRGA/decrypt control.
//   prga_state_t : PRGA/decrypt FSM state encoding
//   CH_*         : bounds of the accepted plaintext character set
//   MSG_LEN_DEF  : default ciphertext length in bytes
//   char_ok()    : true for a lowercase letter or a space
package rc4_pkg;

  localparam int MSG_LEN_DEF = 32;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LO    = 8'h61;
  localparam logic [7:0] CH_HI    = 8'h7A;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INC_I   = 4'd1,
    ST_SEND_SI = 4'd2,
    ST_WAIT_SI = 4'd3,
    ST_CAP_SI  = 4'd4,
    ST_SEND_SJ = 4'd5,
    ST_WAIT_SJ = 4'd6,
    ST_CAP_SJ  = 4'd7,
    ST_WR_SI   = 4'd8,
    ST_WR_SJ   = 4'd9,
    ST_SEND_F  = 4'd10,
    ST_WAIT_F  = 4'd11,
    ST_CAP_F   = 4'd12,
    ST_NEXT_K  = 4'd13,
    ST_DONE    = 4'd14
  } prga_state_t;

  function automatic logic char_ok(input logic [7:0] c);
    return ((c >= CH_LO) && (c <= CH_HI)) || (c == CH_SPACE);
  endfunction

endpackage

// File: rtl/prga_decrypt.sv
// prga_decrypt -- RC4 PRGA stage: walks the shuffled S array, generates one
// keystream byte per ciphertext byte and writes the XOR result out.
//   clk, rst            : clock, synchronous active-high reset
//   In_Start            : level, starts a message when seen in IDLE
//   Finish_ack          : returns DONE to IDLE
//   s_addr/s_data/s_wren/s_q : S-RAM port (registered-read memory)
//   rom_addr/rom_q      : ciphertext ROM port (registered-read memory)
//   out_addr/out_data/out_wren : plaintext RAM write port
//   Decrypt_Finish      : high while in DONE
//   Key_Invalid         : high in DONE if a byte failed the character check
// Every memory read is SEND (address registered), WAIT (memory registers),
// CAPTURE (data consumed). Per byte: 13 cycles.
module prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN  = MSG_LEN_DEF,
  parameter int CHECK_EN = 1,
  // A one-byte message still needs a 1-bit address bus.
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          In_Start,
  input  logic          Finish_ack,
  output logic [7:0]    s_addr,
  output logic [7:0]    s_data,
  output logic          s_wren,
  input  logic [7:0]    s_q,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_q,
  output logic [AW-1:0] out_addr,
  output logic [7:0]    out_data,
  output logic          out_wren,
  output logic          Decrypt_Finish,
  output logic          Key_Invalid
);

  prga_state_t   state;
  logic [7:0]    i;
  logic [7:0]    j;
  logic [7:0]    si;
  logic [7:0]    sj;
  logic [AW-1:0] k;
  logic          bad;
  logic [7:0]    f_byte;
  logic          f_ok;

  assign f_byte = s_q ^ rom_q;
  assign f_ok   = (CHECK_EN == 0) || char_ok(f_byte);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      si       <= '0;
      sj       <= '0;
      s_addr   <= '0;
      s_data   <= '0;
      rom_addr <= '0;
      bad      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          i   <= '0;
          j   <= '0;
          k   <= '0;
          bad <= 1'b0;
          if (In_Start) state <= ST_INC_I;
        end
        ST_INC_I: begin
          i     <= i + 8'd1;
          state <= ST_SEND_SI;
        end
        ST_SEND_SI: begin
          s_addr <= i;
          state  <= ST_WAIT_SI;
        end
        ST_WAIT_SI: state <= ST_CAP_SI;
        ST_CAP_SI: begin
          si    <= s_q;
          j     <= j + s_q;
          state <= ST_SEND_SJ;
        end
        ST_SEND_SJ: begin
          s_addr <= j;
          state  <= ST_WAIT_SJ;
        end
        ST_WAIT_SJ: state <= ST_CAP_SJ;
        ST_CAP_SJ: begin
          // Address/data are staged one state early so they are stable
          // for the whole write cycle that follows.
          sj     <= s_q;
          s_addr <= i;
          s_data <= s_q;
          state  <= ST_WR_SI;
        end
        ST_WR_SI: begin
          s_addr <= j;
          s_data <= si;
          state  <= ST_WR_SJ;
        end
        ST_WR_SJ: state <= ST_SEND_F;
        ST_SEND_F: begin
          s_addr   <= si + sj;
          rom_addr <= k;
          state    <= ST_WAIT_F;
        end
        ST_WAIT_F: state <= ST_CAP_F;
        ST_CAP_F: begin
          if (!f_ok) begin
            bad   <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_NEXT_K;
          end
        end
        ST_NEXT_K: begin
          if (k == AW'(MSG_LEN - 1)) begin
            state <= ST_DONE;
          end else begin
            k     <= k + 1'b1;
            state <= ST_INC_I;
          end
        end
        ST_DONE: begin
          if (Finish_ack) begin
            bad   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_wren         = (state == ST_WR_SI) || (state == ST_WR_SJ);
  assign out_wren       = (state == ST_CAP_F);
  assign out_addr       = k;
  assign out_data       = out_wren ? f_byte : '0;
  assign Decrypt_Finish = (state == ST_DONE);
  assign Key_Invalid    = Decrypt_Finish && bad;

endmodule

// File: tb/tb_prga_decrypt.sv
// tb_prga_decrypt -- directed bench for prga_decrypt. Instance a runs a
// 32-byte message, instance b a 1-byte message. A plain RC4 model produces
// the expected plaintext writes; hand-computed literals pin the model.
module tb_prga_decrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, ack_a, start_b, ack_b;

  logic [7:0] s_addr_a, s_data_a, s_q_a, rom_q_a, out_data_a;
  logic       s_wren_a, out_wren_a, fin_a, kinv_a;
  logic [4:0] rom_addr_a, out_addr_a;

  logic [7:0] s_addr_b, s_data_b, s_q_b, rom_q_b, out_data_b;
  logic       s_wren_b, out_wren_b, fin_b, kinv_b;
  logic [0:0] rom_addr_b, out_addr_b;

  prga_decrypt #(.MSG_LEN(32), .CHECK_EN(1)) dut_a (
    .clk(clk), .rst(rst), .In_Start(start_a), .Finish_ack(ack_a),
    .s_addr(s_addr_a), .s_data(s_data_a), .s_wren(s_wren_a), .s_q(s_q_a),
    .rom_addr(rom_addr_a), .rom_q(rom_q_a),
    .out_addr(out_addr_a), .out_data(out_data_a), .out_wren(out_wren_a),
    .Decrypt_Finish(fin_a), .Key_Invalid(kinv_a)
  );

  prga_decrypt #(.MSG_LEN(1), .CHECK_EN(1)) dut_b (
    .clk(clk), .rst(rst), .In_Start(start_b), .Finish_ack(ack_b),
    .s_addr(s_addr_b), .s_data(s_data_b), .s_wren(s_wren_b), .s_q(s_q_b),
    .rom_addr(rom_addr_b), .rom_q(rom_q_b),
    .out_addr(out_addr_b), .out_data(out_data_b), .out_wren(out_wren_b),
    .Decrypt_Finish(fin_b), .Key_Invalid(kinv_b)
  );

  // ---------------- memories (one-cycle registered read) ----------------
  logic [7:0] img_s[256];
  logic [7:0] img_rom[32];
  logic       load_a, load_b;
  logic [7:0] smem_a[256], rom_a[32], pt_a[32];
  logic [7:0] smem_b[256], rom_b[2], pt_b[2];

  always @(posedge clk) begin
    if (load_a) begin
      for (int x = 0; x < 256; x++) smem_a[x] <= img_s[x];
      for (int x = 0; x < 32; x++) begin
        rom_a[x] <= img_rom[x];
        pt_a[x]  <= 8'hEE;
      end
    end else begin
      if (s_wren_a)   smem_a[s_addr_a] <= s_data_a;
      if (out_wren_a) pt_a[out_addr_a] <= out_data_a;
    end
    s_q_a   <= smem_a[s_addr_a];
    rom_q_a <= rom_a[rom_addr_a];
  end

  always @(posedge clk) begin
    if (load_b) begin
      for (int x = 0; x < 256; x++) smem_b[x] <= img_s[x];
      for (int x = 0; x < 2; x++) begin
        rom_b[x] <= img_rom[x];
        pt_b[x]  <= 8'hEE;
      end
    end else begin
      if (s_wren_b)   smem_b[s_addr_b] <= s_data_b;
      if (out_wren_b) pt_b[out_addr_b] <= out_data_b;
    end
    s_q_b   <= smem_b[s_addr_b];
    rom_q_b <= rom_b[rom_addr_b];
  end

  // ---------------- counters and check helper ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- RC4 reference model ----------------
  logic [7:0] m_s[256];
  logic [7:0] ksa_s[256];
  logic [7:0] m_ks[32];
  logic [7:0] m_ct[32];
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  int m_n;
  bit m_bad;

  task automatic ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
    logic [7:0] key[3];
    logic [7:0] t;
    int unsigned jj;
    key = '{k0, k1, k2};
    for (int x = 0; x < 256; x++) ksa_s[x] = x[7:0];
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + ksa_s[x] + key[x % 3]) % 256;
      t = ksa_s[x]; ksa_s[x] = ksa_s[jj]; ksa_s[jj] = t;
    end
  endtask

  // Plain RC4 PRGA over m_s; leaves m_s as the permuted array.
  task automatic keystream(input int len);
    int unsigned mi, mj;
    logic [7:0] t;
    mi = 0; mj = 0;
    for (int n = 0; n < len; n++) begin
      mi = (mi + 1) % 256;
      mj = (mj + m_s[mi]) % 256;
      t = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = t;
      m_ks[n] = m_s[(m_s[mi] + m_s[mj]) % 256];
    end
  endtask

  // Expected plaintext writes, stopping after the first unacceptable byte.
  task automatic build_expect(input int len, input bit for_b);
    logic [7:0] p;
    m_n = 0; m_bad = 0;
    for (int n = 0; n < len; n++) begin
      p = m_ks[n] ^ m_ct[n];
      if (for_b) exp_b.push_back({n[7:0], p});
      else       exp_a.push_back({n[7:0], p});
      m_n++;
      if (!(((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20))) begin
        m_bad = 1;
        break;
      end
    end
  endtask

  // ---------------- compare process ----------------
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;

  always @(negedge clk) begin
    logic [15:0] e;
    if (out_wren_a) begin
      wr_cnt_a++;
      if (exp_a.size() == 0) begin
        check("unexpected_wr_a", {8'h0, out_data_a}, 64'hFFFF);
      end else begin
        e = exp_a.pop_front();
        check("wr_addr_a", {59'h0, out_addr_a}, {56'h0, e[15:8]});
        check("wr_data_a", {56'h0, out_data_a}, {56'h0, e[7:0]});
      end
    end
    if (out_wren_b) begin
      wr_cnt_b++;
      if (exp_b.size() == 0) begin
        check("unexpected_wr_b", {8'h0, out_data_b}, 64'hFFFF);
      end else begin
        e = exp_b.pop_front();
        check("wr_addr_b", {63'h0, out_addr_b}, {56'h0, e[15:8]});
        check("wr_data_b", {56'h0, out_data_b}, {56'h0, e[7:0]});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run(input bit sel, output int cyc);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    while (((sel ? fin_b : fin_a) == 1'b0) && (cyc < 1000)) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic ack(input bit sel);
    @(negedge clk);
    if (sel) ack_b = 1'b1; else ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0; ack_b = 1'b0;
  endtask

  task automatic load(input bit sel);
    @(negedge clk);
    if (sel) load_b = 1'b1; else load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0;
  endtask

  function automatic logic [63:0] outs_a();
    return {26'h0, s_addr_a, s_data_a, s_wren_a, rom_addr_a, out_addr_a,
            out_data_a, out_wren_a, fin_a, kinv_a};
  endfunction

  function automatic logic [63:0] outs_b();
    return {28'h0, s_addr_b, s_data_b, s_wren_b, rom_addr_b, out_addr_b,
            out_data_b, out_wren_b, fin_b, kinv_b};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int cyc, base, nw, t, diff;
    logic [255:0] msg;
    rst = 1'b1; start_a = 1'b0; ack_a = 1'b0; start_b = 1'b0; ack_b = 1'b0;
    load_a = 1'b0; load_b = 1'b0;
    msg = "the quick brown fox jumps over t";
    repeat (3) @(negedge clk);
    check("reset_outs_a", outs_a(), 64'h0);
    check("reset_outs_b", outs_b(), 64'h0);
    rst = 1'b0;

    // One-byte message, identity S, ciphertext 0x63 -> 'a'; i==j swap.
    for (int x = 0; x < 256; x++) begin m_s[x] = x[7:0]; img_s[x] = x[7:0]; end
    for (int x = 0; x < 32; x++) begin img_rom[x] = 8'h00; m_ct[x] = 8'h00; end
    img_rom[0] = 8'h63; m_ct[0] = 8'h63;
    load(1'b1);
    keystream(1);
    build_expect(1, 1'b1);
    base = wr_cnt_b;
    run(1'b1, cyc);
    check("b_cycles", 64'(cyc), 64'd14);
    check("b_kinv", {63'h0, kinv_b}, 64'h0);
    check("b_pt0", {56'h0, pt_b[0]}, 64'h61);
    check("b_wr_count", 64'(wr_cnt_b - base), 64'd1);
    diff = 0;
    for (int x = 0; x < 256; x++) if (smem_b[x] !== x[7:0]) diff++;
    check("b_s_unchanged", 64'(diff), 64'd0);
    ack(1'b1);
    check("b_after_ack", {62'h0, fin_b, kinv_b}, 64'h0);

    // Invalid first byte: identity S, ciphertext 0x02 -> 0x00.
    img_rom[0] = 8'h02; m_ct[0] = 8'h02;
    for (int x = 0; x < 256; x++) m_s[x] = x[7:0];
    load(1'b0);
    keystream(32);
    build_expect(32, 1'b0);
    base = wr_cnt_a;
    run(1'b0, cyc);
    check("inv_cycles", 64'(cyc), 64'd13);
    check("inv_kinv", {63'h0, kinv_a}, 64'h1);
    check("inv_pt0", {56'h0, pt_a[0]}, 64'h00);
    check("inv_pt1_untouched", {56'h0, pt_a[1]}, 64'hEE);
    check("inv_wr_count", 64'(wr_cnt_a - base), 64'd1);

    // DONE holds with In_Start high and no acknowledge.
    start_a = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("done_hold", {62'h0, fin_a, kinv_a}, 64'h3);
    end
    @(negedge clk);
    ack_a = 1'b1; start_a = 1'b0;
    @(negedge clk);
    ack_a = 1'b0;
    check("done_release", {62'h0, fin_a, kinv_a}, 64'h0);
    exp_a.delete();

    // Full 32-byte message under key 00 02 49.
    ksa(8'h00, 8'h02, 8'h49);
    for (int x = 0; x < 256; x++) begin m_s[x] = ksa_s[x]; img_s[x] = ksa_s[x]; end
    keystream(32);
    for (int n = 0; n < 32; n++) begin
      m_ct[n] = m_ks[n] ^ msg[8*(31-n) +: 8];
      img_rom[n] = m_ct[n];
    end
    load(1'b0);
    build_expect(32, 1'b0);
    base = wr_cnt_a;
    run(1'b0, cyc);
    check("full_cycles", 64'(cyc), 64'd417);
    check("full_kinv", {63'h0, kinv_a}, 64'h0);
    check("full_wr_count", 64'(wr_cnt_a - base), 64'd32);
    for (int n = 0; n < 32; n++)
      check("full_pt", {56'h0, pt_a[n]}, {56'h0, msg[8*(31-n) +: 8]});
    diff = 0;
    for (int x = 0; x < 256; x++) if (smem_a[x] !== m_s[x]) diff++;
    check("full_final_s", 64'(diff), 64'd0);
    ack(1'b0);

    // Reset in WR_SI of byte 5 (the 11th write-enable cycle).
    for (int x = 0; x < 256; x++) m_s[x] = ksa_s[x];
    load(1'b0);
    keystream(5);
    build_expect(5, 1'b0);
    base = wr_cnt_a;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    nw = 0; t = 0;
    while ((nw < 11) && (t < 1000)) begin
      if (s_wren_a) nw++;
      if (nw < 11) begin @(negedge clk); t++; end
    end
    check("rst_reached_wr_si", 64'(nw), 64'd11);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outs_a", outs_a(), 64'h0);
    check("rst_wr_count", 64'(wr_cnt_a - base), 64'd5);
    check("rst_exp_drained", 64'(exp_a.size()), 64'd0);
    rst = 1'b0;
    nw = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (s_wren_a || out_wren_a) nw++;
    end
    check("rst_no_writes", 64'(nw), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
